int32_to_fp32_conv: RTL
=======================

# int32_to_fp32_conv

Multi-cycle converter from a 32-bit integer (signed or unsigned, selected per transaction) to an IEEE-754 single-precision word, rounded to nearest-even. It is the operand-producing side of the floating-point datapath: integer sources pass through it before reaching the SP adder/subtractor, and its output uses the same packed {sign, exp[7:0], frac[22:0]} format. The block is an FSM with valid/ready handshakes on both sides and fixed 7-cycle latency.

## Interface
Parameters: none; widths fixed at 32-bit in / 32-bit out.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- in_valid  input  1  in_int/is_signed valid
- in_ready  output  1  high only in IDLE
- in_int  input  32  integer operand
- is_signed  input  1  1 = two's complement, 0 = unsigned
- out_valid  output  1  out_float/inexact valid; held until accepted
- out_ready  input  1  consumer accepts result
- out_float  output  32  IEEE-754 SP result
- inexact  output  1  rounding discarded nonzero bits

## Operation
- States: IDLE, ABS, NORM, ROUND, DONE.
- IDLE: in_ready=1. On in_valid: capture in_int, is_signed → ABS. Later input changes are ignored.
- ABS: sign = is_signed & in_int[31]; mag[31:0] = sign ? −in_int : in_int (−2^31 yields 0x80000000, correct as unsigned); lz counter = 0 → NORM.
- NORM: 5 cycles, stage k = 0..4 with shift S = 16,8,4,2,1: if mag[31:32−S] == 0 then mag <<= S, lz += S. After stage 4 → ROUND. mag==0 passes through unchanged (lz=31).
- ROUND: if mag==0, result = {sign=0, 0, 0}, inexact=0. Else exp = 158 − lz; frac = mag[30:8]; guard = mag[7]; sticky = |mag[6:0]; round up iff guard & (sticky | frac[0]); frac all-ones + 1 → frac=0, exp+1. inexact = guard | sticky. Register out_float/inexact → DONE.
- DONE: out_valid=1, out_float/inexact stable. On out_ready → IDLE. in_ready rises the next cycle; no overlap of transactions.
- No overflow, NaN, or denormal results are possible (max exp 159).
- Negative zero is never produced.

## Timing
- Reset (async, any state): state=IDLE, in_ready=1 after release, out_valid=0, out_float=0, inexact=0; any transaction in flight is discarded.
- Latency: accepting edge t0 → ABS; t1 → NORM0; t2..t6 complete NORM0..4 → ROUND; out_valid high after edge t7.
- Throughput: one result per 8 cycles minimum (7 + 1 cycle for DONE handshake with out_ready held high).
- out_ready low in DONE: hold indefinitely, outputs unchanged.
- in_valid while not in IDLE: ignored (in_ready=0); source must hold it.

## Structure
- Shared package fp_pkg: FP_EXP_W=8, FP_FRAC_W=23, FP_BIAS=127, state enum conv_state_t, and field-extraction constants reused by the adder.
- One combinational sub-module, fp_round_rne: inputs sign, exp[7:0], normalized mag[31:0]; outputs packed 32-bit float and inexact. Reusable by future FP units.

## Test plan
- Unsigned 1 → 0x3F800000, inexact=0; signed −1 (0xFFFFFFFF) → 0xBF800000; out_valid exactly 7 cycles after acceptance.
- Signed 0x80000000 → 0xCF000000; unsigned 0xFFFFFFFF → 0x4F800000, inexact=1 (rounding carry into exponent).
- Ties to even: 0x01000001 → 0x4B800000, inexact=1; 0x01000003 → 0x4B800002, inexact=1.
- Zero, signed and unsigned → 0x00000000, inexact=0; 0x00FFFFFF → 0x4B7FFFFF, inexact=0.
- Back-pressure: out_ready low 10 cycles in DONE → out_float stable, in_ready=0; in_valid pulsed meanwhile is not accepted.
- Reset asserted during NORM → out_valid=0, out_float=0 immediately; after release a new conversion of 5 yields 0x40A00000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared single-precision floating-point definitions for the FP datapath:
// field widths, field positions, and the integer-to-float converter states.
package fp_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;
    localparam int FP_BIAS   = 127;

    // Bit positions inside the packed {sign, exp, frac} word.
    localparam int FP_SIGN_BIT = 31;
    localparam int FP_EXP_MSB  = 30;
    localparam int FP_EXP_LSB  = 23;
    localparam int FP_FRAC_MSB = 22;
    localparam int FP_FRAC_LSB = 0;

    // Biased exponent of a magnitude whose leading one sits at bit 31.
    localparam logic [FP_EXP_W-1:0] CONV_EXP_BASE = 8'(FP_BIAS + 31);

    localparam logic [2:0] NORM_LAST_STAGE = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS   = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } conv_state_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even packer: turns a sign, biased exponent and normalized
// 32-bit magnitude (leading one at bit 31) into a packed SP float.
module fp_round_rne
    import fp_pkg::*;
(
    input  logic        sign,
    input  logic [7:0]  exp,
    input  logic [31:0] mag,
    output logic [31:0] float_out,
    output logic        inexact
);

    logic [22:0] frac;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [30:0] exp_frac_sum;

    // Adding the round bit to {exp, frac} lets a mantissa carry bump the exponent.
    always_comb begin
        frac         = mag[30:8];
        guard        = mag[7];
        sticky       = |mag[6:0];
        round_up     = guard & (sticky | frac[0]);
        exp_frac_sum = {exp, frac} + {30'd0, round_up};
        if (mag == 32'd0) begin
            float_out = 32'd0;
            inexact   = 1'b0;
        end else begin
            float_out = {sign, exp_frac_sum};
            inexact   = guard | sticky;
        end
    end

endmodule

// File: rtl/int32_to_fp32_conv.sv
// Multi-cycle 32-bit integer to IEEE-754 single converter: capture, take the
// magnitude, normalize with a 5-step leading-zero shifter, then round RNE.
module int32_to_fp32_conv
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_int,
    input  logic        is_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_float,
    output logic        inexact
);

    conv_state_t state;
    conv_state_t state_next;

    logic [31:0] in_int_q;
    logic        is_signed_q;
    logic        sign_q;
    logic [31:0] mag_q;
    logic [4:0]  lz_q;
    logic [2:0]  stage_q;

    logic        top_zero;
    logic [4:0]  shift_amt;
    logic [7:0]  exp_biased;
    logic [31:0] rnd_float;
    logic        rnd_inexact;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = ABS;
            ABS:     state_next = NORM;
            NORM:    if (stage_q == NORM_LAST_STAGE) state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Stage k tests the top 16>>k bits; a zero magnitude simply falls through.
    always_comb begin
        top_zero  = 1'b0;
        shift_amt = 5'd0;
        case (stage_q)
            3'd0:    begin top_zero = (mag_q[31:16] == 16'd0); shift_amt = 5'd16; end
            3'd1:    begin top_zero = (mag_q[31:24] == 8'd0);  shift_amt = 5'd8;  end
            3'd2:    begin top_zero = (mag_q[31:28] == 4'd0);  shift_amt = 5'd4;  end
            3'd3:    begin top_zero = (mag_q[31:30] == 2'd0);  shift_amt = 5'd2;  end
            3'd4:    begin top_zero = (mag_q[31] == 1'b0);     shift_amt = 5'd1;  end
            default: begin top_zero = 1'b0;                    shift_amt = 5'd0;  end
        endcase
    end

    assign exp_biased = CONV_EXP_BASE - {3'd0, lz_q};

    fp_round_rne u_round (
        .sign      (sign_q),
        .exp       (exp_biased),
        .mag       (mag_q),
        .float_out (rnd_float),
        .inexact   (rnd_inexact)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_int_q    <= 32'd0;
            is_signed_q <= 1'b0;
            sign_q      <= 1'b0;
            mag_q       <= 32'd0;
            lz_q        <= 5'd0;
            stage_q     <= 3'd0;
            out_float   <= 32'd0;
            inexact     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_int_q    <= in_int;
                        is_signed_q <= is_signed;
                    end
                end
                ABS: begin
                    sign_q  <= is_signed_q & in_int_q[31];
                    mag_q   <= (is_signed_q & in_int_q[31]) ? -in_int_q : in_int_q;
                    lz_q    <= 5'd0;
                    stage_q <= 3'd0;
                end
                NORM: begin
                    if (top_zero) begin
                        mag_q <= mag_q << shift_amt;
                        lz_q  <= lz_q + shift_amt;
                    end
                    stage_q <= stage_q + 3'd1;
                end
                ROUND: begin
                    out_float <= rnd_float;
                    inexact   <= rnd_inexact;
                end
                default: ;
            endcase
        end
    end

endmodule
